// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard controller:
//   state_t        controller FSM states (RUN, MD_BUSY)
//   REG_ZERO       architectural zero register index (never a real producer)
//   NOP_INSTR      instruction word loaded into a pipeline register on flush
//   hazard_ctrl_t  bundle of all per-cycle pipeline control strobes
//   CTRL_*         canned control bundles for the common cases
// ---------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // addi x0, x0, 0 -- the bubble a flushed register holds (RegWrite=0, MemWrite=0)
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_write;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic md_go;
    logic md_abort;
  } hazard_ctrl_t;

  // While in reset every stage is held with bubbles loaded.
  localparam hazard_ctrl_t CTRL_RESET = '{
    pc_write:    1'b0,
    ifid_write:  1'b0,
    idex_write:  1'b0,
    ifid_flush:  1'b1,
    idex_flush:  1'b1,
    exmem_flush: 1'b1,
    md_go:       1'b0,
    md_abort:    1'b0
  };

  // Free-running pipeline: everything advances, nothing is squashed.
  localparam hazard_ctrl_t CTRL_FREE = '{
    pc_write:    1'b1,
    ifid_write:  1'b1,
    idex_write:  1'b1,
    ifid_flush:  1'b0,
    idex_flush:  1'b0,
    exmem_flush: 1'b0,
    md_go:       1'b0,
    md_abort:    1'b0
  };

  // EX frozen on a multi-cycle op: front end and ID/EX held, EX/MEM gets bubbles.
  localparam hazard_ctrl_t CTRL_MD_FREEZE = '{
    pc_write:    1'b0,
    ifid_write:  1'b0,
    idex_write:  1'b0,
    ifid_flush:  1'b0,
    idex_flush:  1'b0,
    exmem_flush: 1'b1,
    md_go:       1'b0,
    md_abort:    1'b0
  };

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// W-bit up counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high clear (has priority over inc)
//   inc    count this cycle
//   count  current value
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Stall/flush controller for the 5-stage pipeline. Covers the hazards the EX
// forwarding network cannot: load-use, taken-branch wrong path, and MUL/DIV
// occupancy of EX (with a timeout abort). Keeps saturating perf counters.
//
// Parameters:
//   MD_TIMEOUT  max MD_BUSY cycles before the MUL/DIV op is aborted (>= 2)
//   CW          perf counter width
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   rs1_id, rs2_id              ID source registers
//   uses_rs1_id, uses_rs2_id    ID instruction really reads rs1/rs2
//   rd_ex, MemRead_ex           EX destination / EX is a load
//   branch_taken_ex             EX resolved a taken branch or jump
//   muldiv_start_ex             EX holds a MUL/DIV (honoured only in RUN)
//   muldiv_done                 MUL/DIV result valid this cycle
//   pc_write, ifid_write,
//   idex_write                  register enables (0 = hold)
//   ifid_flush, idex_flush,
//   exmem_flush                 load a bubble into that register
//   md_go, md_abort             one-cycle start / timeout-abort pulses
//   md_error                    sticky timeout flag
//   stall_cycles, flush_events  saturating perf counters
// The control strobes are combinational so they act in the current cycle;
// state, busy counter, md_error and counters are registered.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CW         = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    rs1_id,
  input  logic [4:0]    rs2_id,
  input  logic          uses_rs1_id,
  input  logic          uses_rs2_id,
  input  logic [4:0]    rd_ex,
  input  logic          MemRead_ex,
  input  logic          branch_taken_ex,
  input  logic          muldiv_start_ex,
  input  logic          muldiv_done,
  output logic          pc_write,
  output logic          ifid_write,
  output logic          idex_write,
  output logic          ifid_flush,
  output logic          idex_flush,
  output logic          exmem_flush,
  output logic          md_go,
  output logic          md_abort,
  output logic          md_error,
  output logic [CW-1:0] stall_cycles,
  output logic [CW-1:0] flush_events
);

  // Busy counter must be able to hold MD_TIMEOUT itself.
  localparam int BW = $clog2(MD_TIMEOUT + 1);

  state_t       state;
  logic [BW-1:0] busy_cnt;
  hazard_ctrl_t ctrl;
  logic         load_use;
  logic         md_timeout;
  logic         branch_flush;

  // Load-use: EX is a load into a real register that ID is about to read.
  // x0 is never a producer, and an unused source field is a don't-care.
  function automatic logic detect_load_use(
    input logic       mem_read,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       use_rs1,
    input logic       use_rs2
  );
    return mem_read && (rd != REG_ZERO) &&
           ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
  endfunction

  assign load_use   = detect_load_use(MemRead_ex, rd_ex, rs1_id, rs2_id,
                                      uses_rs1_id, uses_rs2_id);
  assign md_timeout = (busy_cnt == BW'(MD_TIMEOUT));

  // -------------------------------------------------------------------------
  // Per-cycle control decision
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path through
    // this block leaves a value unassigned (which would infer a latch).
    ctrl         = CTRL_FREE;
    branch_flush = 1'b0;

    if (rst) begin
      ctrl = CTRL_RESET;
    end else begin
      unique case (state)
        RUN: begin
          if (branch_taken_ex) begin
            // Wrong-path instructions in IF/ID and ID/EX are squashed; any
            // load-use seen in ID belongs to the wrong path and is ignored.
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
            branch_flush    = 1'b1;
          end else if (muldiv_start_ex) begin
            ctrl       = CTRL_MD_FREEZE;
            ctrl.md_go = 1'b1;
          end else if (load_use) begin
            // One bubble into EX; the load result is then forwarded from MEM/WB.
            ctrl.pc_write   = 1'b0;
            ctrl.ifid_write = 1'b0;
            ctrl.idex_flush = 1'b1;
          end
        end

        MD_BUSY: begin
          if (muldiv_done) begin
            // Release: result flows into EX/MEM. Done beats a same-cycle timeout.
            ctrl = CTRL_FREE;
          end else if (md_timeout) begin
            ctrl            = CTRL_MD_FREEZE;
            ctrl.idex_write = 1'b1;
            ctrl.idex_flush = 1'b1;
            ctrl.md_abort   = 1'b1;
          end else begin
            ctrl = CTRL_MD_FREEZE;
          end
        end

        default: ctrl = CTRL_RESET;
      endcase
    end
  end

  assign pc_write    = ctrl.pc_write;
  assign ifid_write  = ctrl.ifid_write;
  assign idex_write  = ctrl.idex_write;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_flush = ctrl.exmem_flush;
  assign md_go       = ctrl.md_go;
  assign md_abort    = ctrl.md_abort;

  // -------------------------------------------------------------------------
  // FSM, busy counter and sticky error
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // Reset out of MD_BUSY is a clean return to RUN; no abort is raised.
      state    <= RUN;
      busy_cnt <= '0;
      md_error <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (ctrl.md_go) begin
            state    <= MD_BUSY;
            busy_cnt <= BW'(1);
          end
        end

        MD_BUSY: begin
          if (muldiv_done || ctrl.md_abort) begin
            state <= RUN;
          end else begin
            busy_cnt <= busy_cnt + BW'(1);
          end
          if (ctrl.md_abort) begin
            md_error <= 1'b1;
          end
        end

        default: state <= RUN;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Performance counters
  // -------------------------------------------------------------------------
  sat_counter #(.W(CW)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~ctrl.pc_write),
    .count (stall_cycles)
  );

  sat_counter #(.W(CW)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (branch_flush),
    .count (flush_events)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed scenarios followed by randomized traffic. The driver applies one
// stimulus per cycle, evaluates a cycle-numbered reference model and queues
// the expected outputs; an independent monitor pops and compares each cycle.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int MD_TIMEOUT = 4;
  localparam int CW         = 3;
  localparam int SAT        = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    rs1_id, rs2_id, rd_ex;
  logic          uses_rs1_id, uses_rs2_id;
  logic          MemRead_ex, branch_taken_ex, muldiv_start_ex, muldiv_done;
  logic          pc_write, ifid_write, idex_write;
  logic          ifid_flush, idex_flush, exmem_flush;
  logic          md_go, md_abort, md_error;
  logic [CW-1:0] stall_cycles, flush_events;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .CW(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .rs1_id          (rs1_id),
    .rs2_id          (rs2_id),
    .uses_rs1_id     (uses_rs1_id),
    .uses_rs2_id     (uses_rs2_id),
    .rd_ex           (rd_ex),
    .MemRead_ex      (MemRead_ex),
    .branch_taken_ex (branch_taken_ex),
    .muldiv_start_ex (muldiv_start_ex),
    .muldiv_done     (muldiv_done),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .idex_write      (idex_write),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .exmem_flush     (exmem_flush),
    .md_go           (md_go),
    .md_abort        (md_abort),
    .md_error        (md_error),
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events)
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       ms;
    logic       done;
  } stim_t;

  typedef struct {
    logic pc_write, ifid_write, idex_write;
    logic ifid_flush, idex_flush, exmem_flush;
    logic md_go, md_abort, md_error;
    logic chk_ifw, chk_idw;  // enable is a don't-care while a bubble is loaded
    int   stall, flush;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_errs   = 0;

  // Reference model state: MUL/DIV tracked by the cycle number of md_go.
  bit m_in_md   = 0;
  int m_go_cyc  = 0;
  int m_cycle   = 0;
  int m_stall   = 0;
  int m_flush   = 0;
  bit m_err     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic apply_model(input stim_t s, output exp_t e);
    bit lu;
    int elapsed;
    e = '{default: 0};
    e.md_error = m_err;
    e.stall    = m_stall;
    e.flush    = m_flush;
    e.chk_ifw  = 1;
    e.chk_idw  = 1;
    if (s.rst) begin
      e.ifid_flush  = 1;
      e.idex_flush  = 1;
      e.exmem_flush = 1;
      m_in_md = 0; m_err = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!m_in_md) begin
        lu = s.mr && (s.rd != 0) &&
             ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
        if (s.br) begin
          e.pc_write = 1; e.ifid_flush = 1; e.idex_flush = 1;
          e.chk_ifw = 0; e.chk_idw = 0;
          if (m_flush < SAT) m_flush++;
        end else if (s.ms) begin
          e.exmem_flush = 1; e.md_go = 1;
          m_in_md = 1; m_go_cyc = m_cycle;
        end else if (lu) begin
          e.idex_flush = 1; e.chk_idw = 0;
        end else begin
          e.pc_write = 1; e.ifid_write = 1; e.idex_write = 1;
        end
      end else begin
        elapsed = m_cycle - m_go_cyc;
        if (s.done) begin
          e.pc_write = 1; e.ifid_write = 1; e.idex_write = 1;
          m_in_md = 0;
        end else if (elapsed == MD_TIMEOUT) begin
          e.md_abort = 1; e.idex_flush = 1; e.exmem_flush = 1; e.chk_idw = 0;
          m_err = 1; m_in_md = 0;
        end else begin
          e.exmem_flush = 1;
        end
      end
      if (!e.pc_write && m_stall < SAT) m_stall++;
    end
    m_cycle++;
  endtask

  task automatic step(input stim_t s, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst             = s.rst;
    rs1_id          = s.rs1;
    rs2_id          = s.rs2;
    uses_rs1_id     = s.u1;
    uses_rs2_id     = s.u2;
    rd_ex           = s.rd;
    MemRead_ex      = s.mr;
    branch_taken_ex = s.br;
    muldiv_start_ex = s.ms;
    muldiv_done     = s.done;
    apply_model(s, e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t rst_s();
    stim_t s;
    s     = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  function automatic stim_t lu_s();  // lw x5 in EX, ID reads x5 on rs2
    stim_t s;
    s = '0;
    s.mr = 1; s.rd = 5; s.u1 = 1; s.rs1 = 3; s.u2 = 1; s.rs2 = 5;
    return s;
  endfunction

  function automatic stim_t md_s(input logic start, input logic done);
    stim_t s;
    s      = '0;
    s.ms   = start;
    s.done = done;
    return s;
  endfunction

  // Monitor: compare whatever the DUT presents against the queued expectation.
  initial begin
    exp_t  e;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, ".pc_write"},    32'(pc_write),    32'(e.pc_write));
        if (e.chk_ifw) check({t, ".ifid_write"}, 32'(ifid_write), 32'(e.ifid_write));
        if (e.chk_idw) check({t, ".idex_write"}, 32'(idex_write), 32'(e.idex_write));
        check({t, ".ifid_flush"},  32'(ifid_flush),  32'(e.ifid_flush));
        check({t, ".idex_flush"},  32'(idex_flush),  32'(e.idex_flush));
        check({t, ".exmem_flush"}, 32'(exmem_flush), 32'(e.exmem_flush));
        check({t, ".md_go"},       32'(md_go),       32'(e.md_go));
        check({t, ".md_abort"},    32'(md_abort),    32'(e.md_abort));
        check({t, ".md_error"},    32'(md_error),    32'(e.md_error));
        check({t, ".stall_cycles"}, 32'(stall_cycles), 32'(e.stall));
        check({t, ".flush_events"}, 32'(flush_events), 32'(e.flush));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver
  initial begin
    stim_t s;
    rst = 1'b1;
    rs1_id = '0; rs2_id = '0; rd_ex = '0;
    uses_rs1_id = 0; uses_rs2_id = 0;
    MemRead_ex = 0; branch_taken_ex = 0; muldiv_start_ex = 0; muldiv_done = 0;
    repeat (2) @(posedge clk);  // settle registers before anything is checked

    // Reset values
    step(rst_s(), "reset");
    step(rst_s(), "reset");

    // Load-use: exactly one stall cycle
    step(lu_s(), "lu");
    s = lu_s(); s.mr = 0; s.rd = 0;  // bubble now in EX, ID unchanged
    step(s, "lu_after");
    step(idle(), "lu_idle");
    @(negedge clk);
    check("lu_stall_total", 32'(stall_cycles), 1);

    // Load to x0 and unused source: no stall
    step(rst_s(), "x0_rst");
    s = '0; s.mr = 1; s.rd = 0; s.u1 = 1; s.rs1 = 0;
    step(s, "ld_x0");
    s = '0; s.mr = 1; s.rd = 7; s.u1 = 0; s.rs1 = 7; s.u2 = 1; s.rs2 = 2;
    step(s, "ld_unused_rs1");
    step(idle(), "x0_idle");
    @(negedge clk);
    check("x0_stall_total", 32'(stall_cycles), 0);

    // Branch and load-use together: branch wins
    step(rst_s(), "br_rst");
    s = lu_s(); s.br = 1;
    step(s, "br_lu");
    step(idle(), "br_idle");
    @(negedge clk);
    check("br_flush_total", 32'(flush_events), 1);
    check("br_stall_total", 32'(stall_cycles), 0);

    // MUL/DIV with done at T+4 (done at T ignored)
    step(rst_s(), "md_rst");
    step(md_s(1, 1), "md_go");
    repeat (3) step(md_s(0, 0), "md_busy");
    step(md_s(0, 1), "md_done");
    step(idle(), "md_idle");
    @(negedge clk);
    check("md_stall_total", 32'(stall_cycles), 4);
    check("md_error_clean", 32'(md_error), 0);

    // Timeout with hazards ignored while busy
    step(rst_s(), "to_rst");
    step(md_s(1, 0), "to_go");
    for (int i = 0; i < 3; i++) begin
      s = lu_s(); s.br = 1; s.ms = 1;
      step(s, "to_busy");
    end
    step(md_s(0, 0), "to_abort");
    step(idle(), "to_run");
    @(negedge clk);
    check("to_error_set", 32'(md_error), 1);
    check("to_stall_total", 32'(stall_cycles), 5);
    repeat (3) step(idle(), "to_sticky");
    @(negedge clk);
    check("to_error_sticky", 32'(md_error), 1);

    // Done coinciding with timeout: done wins
    step(rst_s(), "tod_rst");
    step(md_s(1, 0), "tod_go");
    repeat (3) step(md_s(0, 0), "tod_busy");
    step(md_s(0, 1), "tod_done");
    step(idle(), "tod_idle");
    @(negedge clk);
    check("tod_no_error", 32'(md_error), 0);

    // Saturation, then reset while in MD_BUSY
    step(rst_s(), "sat_rst");
    repeat (10) step(lu_s(), "sat_lu");
    step(idle(), "sat_idle");
    @(negedge clk);
    check("sat_stall_total", 32'(stall_cycles), SAT);
    step(md_s(1, 0), "rb_go");
    step(md_s(0, 0), "rb_busy");
    step(rst_s(), "rb_rst");
    step(idle(), "rb_run");
    @(negedge clk);
    check("rb_stall_cleared", 32'(stall_cycles), 0);
    check("rb_flush_cleared", 32'(flush_events), 0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      s      = '0;
      s.rst  = ($urandom_range(99) < 2);
      s.rd   = 5'($urandom_range(3));
      s.rs1  = 5'($urandom_range(3));
      s.rs2  = 5'($urandom_range(3));
      s.u1   = $urandom_range(1);
      s.u2   = $urandom_range(1);
      s.mr   = ($urandom_range(99) < 40);
      s.br   = ($urandom_range(99) < 15);
      s.ms   = ($urandom_range(99) < 10);
      s.done = ($urandom_range(99) < 20);
      step(s, "rand");
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errs++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
